// File: rtl/pulse_rate_accum_pkg.sv
// Shared types and defaults for the pulse_rate_accum slice.
package pulse_rate_accum_pkg;

  localparam int PRA_CW_DEF = 8;

  typedef logic [PRA_CW_DEF-1:0] cnt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } pra_state_t;

endpackage

// File: rtl/pulse_rate_accum_if.sv
// Count hand-off bus between pulse_rate_accum (master) and the packer (slave).
interface pulse_rate_accum_if
  import pulse_rate_accum_pkg::*;
#(
  parameter int CW = PRA_CW_DEF
);
  logic [CW-1:0] cnt_out;
  logic          cnt_valid;
  logic          cnt_sat;
  logic          cnt_ovr;
  logic [CW-1:0] dt_rej;
  logic          cnt_ack;

  modport master (
    output cnt_out, cnt_valid, cnt_sat, cnt_ovr, dt_rej,
    input  cnt_ack
  );

  modport slave (
    input  cnt_out, cnt_valid, cnt_sat, cnt_ovr, dt_rej,
    output cnt_ack
  );
endinterface

// File: rtl/pulse_rate_accum_timebase.sv
// Interval timer: counts 0..PERIOD-1 while run=1, clears while run=0.
// tc flags the last cycle of each interval.
module pra_timebase #(
  parameter int PERIOD = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tc
);
  localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

  logic [TW-1:0] timer;

  assign tc = run && (timer == LAST);

  // timer advances only while running, wraps at the interval end
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      timer <= '0;
    else if (!run)  timer <= '0;
    else if (tc)    timer <= '0;
    else            timer <= timer + 1'b1;
  end
endmodule

// File: rtl/pulse_rate_accum.sv
// Per-channel pulse rate accumulator with valid/ack hand-off.
// Optional dead-time rejection is enabled by defining PRA_DEADTIME_EN.
module pulse_rate_accum
  import pulse_rate_accum_pkg::*;
#(
  parameter int CW       = PRA_CW_DEF,
  parameter int PERIOD   = 1024,
  parameter int DEAD_CYC = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic pls_in,
  output logic busy,
  pulse_rate_accum_if.master cnt_if
);
  localparam logic [CW-1:0] CNT_MAX = '1;

  pra_state_t    state;
  logic          terminal;
  logic          count_pls;
  logic [CW-1:0] acc;
  logic [CW-1:0] acc_sum;
  logic          sat_acc;

  // Counting follows enable directly so the first enabled cycle is timer=0.
  pra_timebase #(.PERIOD(PERIOD)) u_timebase (
    .clock (clock),
    .reset (reset),
    .run   (enable),
    .tc    (terminal)
  );

  assign acc_sum = (acc == CNT_MAX) ? acc : acc + CW'(count_pls);

`ifdef PRA_DEADTIME_EN
  localparam int DTW = $clog2(DEAD_CYC + 1);

  logic [DTW-1:0] dt_cnt;
  logic           rej_pls;
  logic [CW-1:0]  rej_acc;
  logic [CW-1:0]  rej_sum;

  assign count_pls = pls_in && (dt_cnt == '0);
  assign rej_pls   = pls_in && (dt_cnt != '0);
  assign rej_sum   = (rej_acc == CNT_MAX) ? rej_acc : rej_acc + CW'(rej_pls);

  // dead-time window opened by each counted pulse; spans interval boundaries
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               dt_cnt <= '0;
    else if (!enable)        dt_cnt <= '0;
    else if (count_pls)      dt_cnt <= DTW'(DEAD_CYC);
    else if (dt_cnt != '0)   dt_cnt <= dt_cnt - 1'b1;
  end

  // reject counter, latched alongside the interval count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rej_acc       <= '0;
      cnt_if.dt_rej <= '0;
    end else if (!enable) begin
      rej_acc <= '0;
    end else if (terminal) begin
      rej_acc       <= '0;
      cnt_if.dt_rej <= rej_sum;
    end else begin
      rej_acc <= rej_sum;
    end
  end
`else
  wire unused_dead_cyc = (DEAD_CYC != 0);

  assign count_pls     = pls_in;
  assign cnt_if.dt_rej = '0;
`endif

  // IDLE/COUNT tracking with registered busy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (enable)  begin state <= COUNT; busy <= 1'b1; end
        COUNT:   if (!enable) begin state <= IDLE;  busy <= 1'b0; end
        default: begin state <= IDLE; busy <= 1'b0; end
      endcase
    end
  end

  // saturating accumulator, restarted at each interval end or on disable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      sat_acc <= 1'b0;
    end else if (!enable || terminal) begin
      acc     <= '0;
      sat_acc <= 1'b0;
    end else begin
      acc     <= acc_sum;
      sat_acc <= sat_acc | (acc_sum == CNT_MAX);
    end
  end

  // latch the interval total and run the valid/ack/overwrite handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_if.cnt_out   <= '0;
      cnt_if.cnt_valid <= 1'b0;
      cnt_if.cnt_sat   <= 1'b0;
      cnt_if.cnt_ovr   <= 1'b0;
    end else if (terminal) begin
      cnt_if.cnt_out   <= acc_sum;
      cnt_if.cnt_sat   <= sat_acc | (acc_sum == CNT_MAX);
      cnt_if.cnt_valid <= 1'b1;
      if (cnt_if.cnt_valid && !cnt_if.cnt_ack)     cnt_if.cnt_ovr <= 1'b1;
      else if (cnt_if.cnt_valid && cnt_if.cnt_ack) cnt_if.cnt_ovr <= 1'b0;
    end else if (cnt_if.cnt_valid && cnt_if.cnt_ack) begin
      cnt_if.cnt_valid <= 1'b0;
      cnt_if.cnt_ovr   <= 1'b0;
    end
  end
endmodule
